// File: rtl/fifo_axis_packetizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_packetizer_pkg
//  Description : Shared types and constants for the FIFO-to-AXI4-Stream
//                packetizer and its skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_axis_packetizer_pkg;

  // Depth of the output skid buffer, and the width of its fill counter
  localparam int SKID_DEPTH_C     = 2;
  localparam int SKID_FILL_W_C    = 2;

  // Data width of the default skid entry (matches the packetizer default)
  localparam int PKG_DATA_WIDTH_C = 32;

  // Packetizer FSM states; PAD is only reachable when the pad/timeout
  // feature is compiled in
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  // One skid-buffer entry: payload plus AXI-S sideband
  typedef struct packed {
    logic [PKG_DATA_WIDTH_C-1:0] data;
    logic                        last;
    logic                        user;
  } skid_entry_t;

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Two-entry in-order registered skid buffer. The producer
//                pushes only while fill < SKID_DEPTH_C; entry 0 is presented
//                on the AXI-S side. Push and pop in the same cycle keep fill
//                unchanged. The entry type is a parameter so other AXI-S
//                sources can reuse it with their own payload layout.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer
  import fifo_axis_packetizer_pkg::*;
#(
  parameter type ENTRY_T = skid_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ENTRY_T                   push_entry,
  output logic [SKID_FILL_W_C-1:0] fill,
  output logic                     m_valid,
  input  logic                     m_ready,
  output ENTRY_T                   m_entry
);

  localparam logic [SKID_FILL_W_C-1:0] FILL_ONE_C  = SKID_FILL_W_C'(1);
  localparam logic [SKID_FILL_W_C-1:0] FILL_FULL_C = SKID_FILL_W_C'(SKID_DEPTH_C);

  ENTRY_T                   entry0_q, entry0_d;
  ENTRY_T                   entry1_q, entry1_d;
  logic [SKID_FILL_W_C-1:0] fill_q, fill_d;
  logic                     pop;

  // Next-state of the two entries and fill level for push/pop combinations
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    fill_d   = fill_q;
    pop      = (fill_q != '0) && m_ready;
    case ({push, pop})
      2'b01: begin
        entry0_d = entry1_q;
        fill_d   = fill_q - FILL_ONE_C;
      end
      2'b10: begin
        // A push into a full buffer is dropped; the producer never does this
        if (fill_q == '0) begin
          entry0_d = push_entry;
          fill_d   = fill_q + FILL_ONE_C;
        end else if (fill_q != FILL_FULL_C) begin
          entry1_d = push_entry;
          fill_d   = fill_q + FILL_ONE_C;
        end
      end
      2'b11: begin
        if (fill_q == FILL_ONE_C) begin
          entry0_d = push_entry;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_entry;
        end
      end
      default: begin
      end
    endcase
  end

  // Entry and fill registers; reset empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      fill_q   <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      fill_q   <= fill_d;
    end
  end

  assign fill    = fill_q;
  assign m_valid = (fill_q != '0);
  assign m_entry = entry0_q;

endmodule
`default_nettype wire

// File: rtl/fifo_axis_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_packetizer
//  Description : Pops a first-word-fall-through FIFO and frames the words
//                into AXI4-Stream packets of cr_packet_length beats, tlast on
//                the final beat. The pop decision uses only registered state
//                and fifo_egr_empty; a 2-entry skid buffer absorbs tready.
//                Optional macro FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN adds a
//                starvation timeout that pads the packet with zero beats
//                (tuser=1) and adds the cr_timeout / mst_tuser ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_packetizer
  import fifo_axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH_P = 32,
  parameter int LEN_WIDTH_P  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    fifo_egr_enable,
  input  logic [DATA_WIDTH_P-1:0] fifo_egr_data,
  input  logic                    fifo_egr_empty,
  output logic                    mst_tvalid,
  input  logic                    mst_tready,
  output logic [DATA_WIDTH_P-1:0] mst_tdata,
  output logic                    mst_tlast,
`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
  output logic                    mst_tuser,
  input  logic [15:0]             cr_timeout,
`endif
  input  logic                    cr_enable,
  input  logic [LEN_WIDTH_P-1:0]  cr_packet_length,
  output logic [31:0]             sr_packet_count,
  output logic                    sr_busy
);

  typedef struct packed {
    logic [DATA_WIDTH_P-1:0] data;
    logic                    last;
    logic                    user;
  } entry_t;

  localparam logic [LEN_WIDTH_P-1:0]   LEN_ONE_C   = LEN_WIDTH_P'(1);
  localparam logic [SKID_FILL_W_C-1:0] FILL_FULL_C = SKID_FILL_W_C'(SKID_DEPTH_C);

  state_e                   state_q, state_d;
  logic [LEN_WIDTH_P-1:0]   len_q, len_d;
  logic [LEN_WIDTH_P-1:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]               last_pend_q, last_pend_d;
  logic [31:0]              pkt_cnt_q, pkt_cnt_d;
  logic                     busy_q, busy_d;

  logic                     start_ok;
  logic                     beat_last;
  logic                     skid_room;
  logic                     pop;
  logic                     push;
  logic                     push_last;
  logic                     hs_last;
  entry_t                   push_entry;
  entry_t                   out_entry;
  logic [SKID_FILL_W_C-1:0] skid_fill;

`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
  logic [15:0]              to_cnt_q, to_cnt_d;
  logic                     timeout_hit;
`endif

  assign start_ok  = cr_enable && (cr_packet_length != '0);
  assign beat_last = (beat_cnt_q == (len_q - LEN_ONE_C));
  assign skid_room = (skid_fill != FILL_FULL_C);

`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
  // Count consecutive empty cycles while a packet is partially sent
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if ((state_q == ST_RUN) && fifo_egr_empty && (beat_cnt_q != '0) &&
        (cr_timeout != '0)) begin
      to_cnt_d    = to_cnt_q + 16'd1;
      timeout_hit = ((to_cnt_q + 16'd1) == cr_timeout);
    end
  end
`endif

  // Packet FSM: start/relatch, beat tagging, pop and push generation
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    beat_cnt_d      = beat_cnt_q;
    pop             = 1'b0;
    push            = 1'b0;
    push_entry.data = fifo_egr_data;
    push_entry.last = beat_last;
    push_entry.user = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_RUN;
          len_d      = cr_packet_length;
          beat_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (!fifo_egr_empty && skid_room) begin
          pop  = 1'b1;
          push = 1'b1;
          if (beat_last) begin
            beat_cnt_d = '0;
            if (start_ok) begin
              len_d = cr_packet_length;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_ONE_C;
          end
        end
`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_PAD;
        end
`endif
      end
`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
      ST_PAD: begin
        push_entry.data = '0;
        push_entry.user = 1'b1;
        if (skid_room) begin
          push = 1'b1;
          if (beat_last) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_ONE_C;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status: completed-packet counter and busy tracking of undelivered tlast
  always_comb begin
    push_last   = push && push_entry.last;
    hs_last     = mst_tvalid && mst_tready && out_entry.last;
    pkt_cnt_d   = hs_last ? (pkt_cnt_q + 32'd1) : pkt_cnt_q;
    last_pend_d = last_pend_q;
    if (push_last && !hs_last) begin
      last_pend_d = last_pend_q + 2'd1;
    end else if (!push_last && hs_last) begin
      last_pend_d = last_pend_q - 2'd1;
    end
    busy_d = (state_d != ST_IDLE) || (last_pend_d != 2'd0);
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      last_pend_q <= '0;
      pkt_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      last_pend_q <= last_pend_d;
      pkt_cnt_q   <= pkt_cnt_d;
      busy_q      <= busy_d;
    end
  end

`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
  // Starvation timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  axis_skid_buffer #(
    .ENTRY_T    (entry_t)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .fill       (skid_fill),
    .m_valid    (mst_tvalid),
    .m_ready    (mst_tready),
    .m_entry    (out_entry)
  );

  assign fifo_egr_enable = pop;
  assign mst_tdata       = out_entry.data;
  assign mst_tlast       = out_entry.last;
  assign sr_packet_count = pkt_cnt_q;
  assign sr_busy         = busy_q;

`ifdef FIFO_AXIS_PACKETIZER_PAD_TIMEOUT_EN
  assign mst_tuser = out_entry.user;
`else
  // Sideband bit is constant zero when padding is not built
  logic unused_user;
  assign unused_user = out_entry.user;
`endif

endmodule
`default_nettype wire
